// File: rtl/fifo_pkg.sv
// Pointer-width derivation and binary-to-Gray conversion, shared by the write
// and read pointer handlers of the asynchronous FIFO.
package fifo_pkg;

  localparam int MAX_PTR_W = 32;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Callers zero-extend into MAX_PTR_W bits and cast the result back down.
  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/wptr_full_handler_if.sv
// Write-side pointer/status bundle. The master modport is the pointer handler.
// The almost_full and wlevel signals exist only when WPTR_ALMOST_FULL_EN is defined.
interface wptr_full_handler_if #(
  parameter int PTR_WIDTH = 4
);
  logic                 w_en;
  logic [PTR_WIDTH:0]   g_rptr_sync;
  logic [PTR_WIDTH:0]   b_wptr;
  logic [PTR_WIDTH:0]   g_wptr;
  logic                 full;
  logic                 overflow;
`ifdef WPTR_ALMOST_FULL_EN
  logic                 almost_full;
  logic [PTR_WIDTH:0]   wlevel;

  modport master (
    input  w_en, g_rptr_sync,
    output b_wptr, g_wptr, full, overflow, almost_full, wlevel
  );
  modport slave (
    output w_en, g_rptr_sync,
    input  b_wptr, g_wptr, full, overflow, almost_full, wlevel
  );
`else
  modport master (
    input  w_en, g_rptr_sync,
    output b_wptr, g_wptr, full, overflow
  );
  modport slave (
    output w_en, g_rptr_sync,
    input  b_wptr, g_wptr, full, overflow
  );
`endif
endinterface

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/wptr_full_handler.sv
// Write-domain pointer, full and sticky-overflow logic for the asynchronous FIFO.
// Optional: define WPTR_ALMOST_FULL_EN to add the registered almost_full and wlevel.
module wptr_full_handler
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = ptr_width(DEPTH),
  parameter int AF_MARGIN  = 2
) (
  input  logic              wclk,
  input  logic              wrst,
  wptr_full_handler_if.master wif
);

  localparam int PW = PTR_WIDTH + 1;

  logic [PTR_WIDTH:0] r_b_wptr;
  logic [PTR_WIDTH:0] r_g_wptr;
  logic               r_full;
  logic               r_overflow;

  logic               w_wr_ok;
  logic [PTR_WIDTH:0] w_b_next;
  logic [PTR_WIDTH:0] w_g_next;
  logic [PTR_WIDTH:0] w_full_cmp;
  logic               w_full_next;

  // The full flag blocks the pointer increment, so the memory write enable
  // (driven from the same wr_ok term) is never active while full.
  assign w_wr_ok     = wif.w_en & ~r_full;
  assign w_b_next    = r_b_wptr + PW'(w_wr_ok);
  assign w_g_next    = PW'(bin2gray(MAX_PTR_W'(w_b_next)));
  assign w_full_cmp  = {~wif.g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1],
                        wif.g_rptr_sync[PTR_WIDTH-2:0]};
  assign w_full_next = (w_g_next == w_full_cmp);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_b_wptr   <= '0;
      r_g_wptr   <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_b_wptr   <= w_b_next;
      r_g_wptr   <= w_g_next;
      r_full     <= w_full_next;
      r_overflow <= r_overflow | (wif.w_en & r_full);
    end
  end

  assign wif.b_wptr   = r_b_wptr;
  assign wif.g_wptr   = r_g_wptr;
  assign wif.full     = r_full;
  assign wif.overflow = r_overflow;

`ifdef WPTR_ALMOST_FULL_EN
  localparam logic [PTR_WIDTH:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

  logic [PTR_WIDTH:0] w_rbin;
  logic [PTR_WIDTH:0] w_wlevel_next;
  logic [PTR_WIDTH:0] r_wlevel;
  logic               r_almost_full;

  gray2bin #(.WIDTH(PW)) u_rptr_g2b (
    .i_gray (wif.g_rptr_sync),
    .o_bin  (w_rbin)
  );

  assign w_wlevel_next = w_b_next - w_rbin;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_wlevel      <= '0;
      r_almost_full <= 1'b0;
    end else begin
      r_wlevel      <= w_wlevel_next;
      r_almost_full <= (w_wlevel_next >= AF_THRESH);
    end
  end

  assign wif.wlevel      = r_wlevel;
  assign wif.almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_wptr_full_handler.sv
// Directed self-checking bench for wptr_full_handler (DEPTH=16): reset, fill,
// overflow, drain release, wrap with a tracking reader, and optional almost-full.
module tb_wptr_full_handler;

  localparam int DEPTH = 16;
  localparam int PTR_WIDTH = 4;

  logic wclk = 1'b0;
  logic wrst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  wptr_full_handler_if #(.PTR_WIDTH(PTR_WIDTH)) wif ();

  wptr_full_handler #(
    .DATA_WIDTH (8),
    .DEPTH      (DEPTH),
    .PTR_WIDTH  (PTR_WIDTH),
    .AF_MARGIN  (2)
  ) dut (
    .wclk (wclk),
    .wrst (wrst),
    .wif  (wif)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [4:0] exp_b;
  logic [4:0] rd_b;

  initial begin
    wif.w_en        = 1'b0;
    wif.g_rptr_sync = '0;

    // Reset state while wrst is held
    #3;
    check("rst_b_wptr", 32'(wif.b_wptr), 32'h0);
    check("rst_g_wptr", 32'(wif.g_wptr), 32'h0);
    check("rst_full", 32'(wif.full), 32'h0);
    check("rst_overflow", 32'(wif.overflow), 32'h0);
    step();
    wrst = 1'b0;

    // Fill: 16 writes with the reader parked at 0
    wif.w_en = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      check($sformatf("fill_b_%0d", i), 32'(wif.b_wptr), 32'(i));
      check($sformatf("fill_full_%0d", i), 32'(wif.full), (i == DEPTH) ? 32'h1 : 32'h0);
`ifdef WPTR_ALMOST_FULL_EN
      if (i == 13) begin
        check("af_13", 32'(wif.almost_full), 32'h0);
        check("wlevel_13", 32'(wif.wlevel), 32'd13);
      end
      if (i == 14) begin
        check("af_14", 32'(wif.almost_full), 32'h1);
        check("wlevel_14", 32'(wif.wlevel), 32'd14);
      end
`endif
    end
    check("fill_g_wptr", 32'(wif.g_wptr), 32'b11000);
    check("fill_overflow", 32'(wif.overflow), 32'h0);

    // Overflow: three more attempts while full
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("ovf_b_%0d", i), 32'(wif.b_wptr), 32'b10000);
      check($sformatf("ovf_full_%0d", i), 32'(wif.full), 32'h1);
      check($sformatf("ovf_flag_%0d", i), 32'(wif.overflow), 32'h1);
    end
    wif.w_en = 1'b0;
    step();
    check("ovf_sticky", 32'(wif.overflow), 32'h1);
    check("ovf_g_hold", 32'(wif.g_wptr), 32'b11000);

    // Drain release: reader advances one entry
    wif.g_rptr_sync = 5'b00001;
    check("drain_full_before_edge", 32'(wif.full), 32'h1);
    step();
    check("drain_full", 32'(wif.full), 32'h0);
    check("drain_b_hold", 32'(wif.b_wptr), 32'b10000);
    wif.w_en = 1'b1;
    step();
    check("refill_b", 32'(wif.b_wptr), 32'b10001);
    check("refill_g", 32'(wif.g_wptr), 32'b11001);
    check("refill_full", 32'(wif.full), 32'h1);
    wif.w_en = 1'b0;
    step();
    check("refill_overflow", 32'(wif.overflow), 32'h1);

    // Asynchronous reset mid-cycle, observed before the next edge
    #2;
    wrst = 1'b1;
    #1;
    check("amid_b_wptr", 32'(wif.b_wptr), 32'h0);
    check("amid_g_wptr", 32'(wif.g_wptr), 32'h0);
    check("amid_full", 32'(wif.full), 32'h0);
    check("amid_overflow", 32'(wif.overflow), 32'h0);
    wif.g_rptr_sync = '0;
    #1;
    wrst = 1'b0;

    // Wrap: 40 writes, reader keeps level at most 8
    exp_b = '0;
    rd_b  = '0;
    wif.w_en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      exp_b = exp_b + 5'd1;
      check($sformatf("wrap_b_%0d", i), 32'(wif.b_wptr), 32'(exp_b));
      check($sformatf("wrap_g_%0d", i), 32'(wif.g_wptr), 32'(gray5(exp_b)));
      check($sformatf("wrap_full_%0d", i), 32'(wif.full), 32'h0);
      if (5'(exp_b - rd_b) >= 5'd8) rd_b = rd_b + 5'd1;
      wif.g_rptr_sync = gray5(rd_b);
    end
    check("wrap_final_b", 32'(wif.b_wptr), 32'd8);
    check("wrap_overflow", 32'(wif.overflow), 32'h0);
    wif.w_en = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
